// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned ADDR_LEN_DEF = 16;
  localparam int unsigned INSTR_W_DEF  = 16;

  typedef enum logic [2:0] {
    ISSUE,
    WAIT,
    UPDATE,
    HOLD,
    HALT
  } fetch_state_e;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Wait-state counter for the fetch stage; expire_o flags the cycle the limit is hit.
module fetch_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expire_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Fires on the counting cycle that takes the count to TIMEOUT_CYCLES.
  assign expire_o = count_en_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (count_en_i)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge Clk) begin
    if (Rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: memory handshake, decode hand-off and next-PC generation.
// Optional wait-state timeout with sticky fault is enabled by FETCH_TIMEOUT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDRESS_LENGTH = ADDR_LEN_DEF,
  parameter int unsigned INSTR_WIDTH    = INSTR_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [ADDRESS_LENGTH-1:0] PCReadAddr,
  output logic [ADDRESS_LENGTH-1:0] PCWriteAddr,
  output logic                      PCEnable,
  output logic                      MemReq,
  output logic [ADDRESS_LENGTH-1:0] MemAddr,
  input  logic                      MemAck,
  input  logic [INSTR_WIDTH-1:0]    MemData,
  input  logic                      BranchTaken,
  input  logic [ADDRESS_LENGTH-1:0] BranchTarget,
  input  logic                      Stall,
  output logic                      InstrValid,
  output logic [INSTR_WIDTH-1:0]    Instr,
  output logic [ADDRESS_LENGTH-1:0] InstrPC,
  output logic                      FetchFault
);

  fetch_state_e              st_q, st_d;
  logic                      req_q, req_d;
  logic [ADDRESS_LENGTH-1:0] addr_q, addr_d;
  logic                      valid_q, valid_d;
  logic [INSTR_WIDTH-1:0]    instr_q, instr_d;
  logic [ADDRESS_LENGTH-1:0] ipc_q, ipc_d;
  logic [ADDRESS_LENGTH-1:0] pcw_q, pcw_d;
  logic                      pcen_q, pcen_d;
  logic                      pend_q, pend_d;
  logic [ADDRESS_LENGTH-1:0] tgt_q, tgt_d;
  logic                      ack;

  assign ack = MemAck && req_q;

`ifdef FETCH_TIMEOUT_EN
  logic fault_q, fault_d;
  logic expire;

  fetch_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .Clk       (Clk),
    .Rst       (Rst),
    .clear_i   (st_q == ISSUE),
    .count_en_i((st_q == WAIT) && !ack),
    .expire_o  (expire)
  );

  assign FetchFault = fault_q;
`else
  // Timeout disabled: the fault can never be raised.
  assign FetchFault = (TIMEOUT_CYCLES == 0) & 1'b0;
`endif

  always_comb begin
    st_d    = st_q;
    req_d   = req_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    pcw_d   = pcw_q;
    pcen_d  = pcen_q;
    pend_d  = pend_q;
    tgt_d   = tgt_q;
`ifdef FETCH_TIMEOUT_EN
    fault_d = fault_q;
`endif
    case (st_q)
      ISSUE: begin
        if (BranchTaken) begin
          valid_d = 1'b0;
          pcw_d   = BranchTarget;
          pcen_d  = 1'b1;
          st_d    = UPDATE;
        end else begin
          req_d  = 1'b1;
          addr_d = PCReadAddr;
          st_d   = WAIT;
        end
      end
      WAIT: begin
        if (ack) begin
          req_d  = 1'b0;
          pcen_d = 1'b1;
          pend_d = 1'b0;
          st_d   = UPDATE;
          // A redirect arriving with the ack counts as pending and wins over the stored one.
          if (BranchTaken)
            pcw_d = BranchTarget;
          else if (pend_q)
            pcw_d = tgt_q;
          else begin
            instr_d = MemData;
            ipc_d   = addr_q;
            valid_d = 1'b1;
            pcw_d   = addr_q + ADDRESS_LENGTH'(1);
          end
        end else begin
          if (BranchTaken) begin
            pend_d = 1'b1;
            tgt_d  = BranchTarget;
          end
`ifdef FETCH_TIMEOUT_EN
          if (expire) begin
            fault_d = 1'b1;
            req_d   = 1'b0;
            st_d    = HALT;
          end
`endif
        end
      end
      UPDATE: begin
        if (BranchTaken)
          pcw_d = BranchTarget;
        else begin
          pcen_d = 1'b0;
          // With nothing to hand to decode (redirected fetch) go straight back to ISSUE.
          st_d   = valid_q ? HOLD : ISSUE;
        end
      end
      HOLD: begin
        if (BranchTaken) begin
          valid_d = 1'b0;
          pcw_d   = BranchTarget;
          pcen_d  = 1'b1;
          st_d    = UPDATE;
        end else if (!Stall) begin
          valid_d = 1'b0;
          st_d    = ISSUE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      st_q    <= ISSUE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
      pcw_q   <= '0;
      pcen_q  <= 1'b0;
      pend_q  <= 1'b0;
      tgt_q   <= '0;
`ifdef FETCH_TIMEOUT_EN
      fault_q <= 1'b0;
`endif
    end else begin
      st_q    <= st_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      pcw_q   <= pcw_d;
      pcen_q  <= pcen_d;
      pend_q  <= pend_d;
      tgt_q   <= tgt_d;
`ifdef FETCH_TIMEOUT_EN
      fault_q <= fault_d;
`endif
    end
  end

  assign MemReq      = req_q;
  assign MemAddr     = addr_q;
  assign InstrValid  = valid_q;
  assign Instr       = instr_q;
  assign InstrPC     = ipc_q;
  assign PCWriteAddr = pcw_q;
  assign PCEnable    = pcen_q;

endmodule
